// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants and segment ordering for the seven-segment scanner
package seg7_pkg;

    // Segment bit positions inside a glyph word: seg[6:0] = g,f,e,d,c,b,a
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg7_t;

    // High-true glyphs; a set bit lights the segment
    localparam seg7_t GLYPH_0    = 7'b0111111;
    localparam seg7_t GLYPH_1    = 7'b0000110;
    localparam seg7_t GLYPH_2    = 7'b1011011;
    localparam seg7_t GLYPH_3    = 7'b1001111;
    localparam seg7_t GLYPH_4    = 7'b1100110;
    localparam seg7_t GLYPH_5    = 7'b1101101;
    localparam seg7_t GLYPH_6    = 7'b1111101;
    localparam seg7_t GLYPH_7    = 7'b0000111;
    localparam seg7_t GLYPH_8    = 7'b1111111;
    localparam seg7_t GLYPH_9    = 7'b1101111;
    localparam seg7_t GLYPH_DASH = 7'b1000000;
    localparam seg7_t GLYPH_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to high-true seven-segment decoder
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Decode one BCD digit; codes above 9 show a dash so bad counter data is visible
    always_comb begin
        case (bcd)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed seven-segment scanner with dead-time and zero blanking
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [1:0] idx
);

    localparam int              PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   TC      = PW'(SCAN_DIV - 1);
    localparam logic [PW:0]     GUARD_W = (PW + 1)'(GUARD);
    // XOR masks applied only at the output register; also the idle pattern
    localparam logic [3:0]      AN_POL  = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic [6:0]      SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [15:0]   shadow;
    logic [PW-1:0] presc;
    logic [3:0]    sel_digit;
    seg7_t         glyph;
    logic          blank;
    logic          in_guard;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    // Snapshot the counter chain; the display never looks at d0..d3 directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= 16'h0000;
        end else if (load) begin
            shadow <= {d3, d2, d1, d0};
        end
    end

    // Slot prescaler and digit index; index advances on prescaler wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (presc == TC) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Pick the shadow digit for the current slot and decide whether it is a leading zero
    always_comb begin
        sel_digit = shadow[3:0];
        blank     = 1'b0;
        case (idx)
            2'd0: begin
                sel_digit = shadow[3:0];
                blank     = 1'b0;
            end
            2'd1: begin
                sel_digit = shadow[7:4];
                blank     = (shadow[15:4] == 12'h000);
            end
            2'd2: begin
                sel_digit = shadow[11:8];
                blank     = (shadow[15:8] == 8'h00);
            end
            default: begin
                sel_digit = shadow[15:12];
                blank     = (shadow[15:12] == 4'h0);
            end
        endcase
        blank = blank && (BLANK_LZ != 0);
    end

    bcd_to_seg7 u_dec (
        .bcd (sel_digit),
        .seg (glyph)
    );

    // High-true next output: dark during the guard window, else one anode plus glyph
    always_comb begin
        in_guard = ({1'b0, presc} < GUARD_W);
        an_next  = 4'b0000;
        seg_next = GLYPH_OFF;
        if (!in_guard) begin
            an_next  = 4'b0001 << idx;
            seg_next = blank ? GLYPH_OFF : glyph;
        end
    end

    // Output register with polarity applied here only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_POL;
            seg <= SEG_POL;
        end else begin
            an  <= an_next ^ AN_POL;
            seg <= seg_next ^ SEG_POL;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan
module tb_seg7_scan;

    localparam int SD = 4;
    localparam int G  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;
    logic       load = 1'b0;
    logic [3:0] an, an_b;
    logic [6:0] seg, seg_b;
    logic [1:0] idx, idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg_b;
        logic [1:0] idx;
    } exp_t;

    exp_t q[$];

    int          m_presc  = 0;
    int          m_idx    = 0;
    logic [15:0] m_shadow = 16'h0;

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(SD), .GUARD(G), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .load(load),
        .an(an), .seg(seg), .idx(idx)
    );

    seg7_scan #(.SCAN_DIV(SD), .GUARD(G), .ACTIVE_LOW(1), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .load(load),
        .an(an_b), .seg(seg_b), .idx(idx_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input int i, input bit blz);
        logic [15:0] hi;
        hi = m_shadow >> (4 * i);
        if (blz && i > 0 && hi == 16'h0) return 7'h00;
        return ref_glyph(m_shadow[4*i +: 4]);
    endfunction

    // One clock: predict, push, clock, pop and compare away from the edge
    task automatic tick();
        exp_t        e;
        int          np, ni;
        logic [15:0] ns;
        if (rst) begin
            e.an = 4'hF; e.seg = 7'h7F; e.seg_b = 7'h7F; e.idx = 2'd0;
            np = 0; ni = 0; ns = 16'h0;
        end else begin
            if (m_presc < G) begin
                e.an = 4'hF; e.seg = 7'h7F; e.seg_b = 7'h7F;
            end else begin
                e.an    = ~(4'b0001 << m_idx);
                e.seg   = ~model_seg(m_idx, 1'b1);
                e.seg_b = ~model_seg(m_idx, 1'b0);
            end
            ns = load ? {d3, d2, d1, d0} : m_shadow;
            if (m_presc == SD - 1) begin
                np = 0; ni = (m_idx + 1) % 4;
            end else begin
                np = m_presc + 1; ni = m_idx;
            end
            e.idx = 2'(ni);
        end
        q.push_back(e);
        @(posedge clk);
        m_presc = np; m_idx = ni; m_shadow = ns;
        @(negedge clk);
        e = q.pop_front();
        check_val("an",    32'(an),    32'(e.an));
        check_val("seg",   32'(seg),   32'(e.seg));
        check_val("idx",   32'(idx),   32'(e.idx));
        check_val("an_b",  32'(an_b),  32'(e.an));
        check_val("seg_b", 32'(seg_b), 32'(e.seg_b));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load_digits(input logic [3:0] a3, input logic [3:0] a2,
                               input logic [3:0] a1, input logic [3:0] a0);
        d3 = a3; d2 = a2; d1 = a1; d0 = a0;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int guard_cnt;
        #1 rst = 1'b1;
        #1;
        check_val("rst_an",  32'(an),  32'h0F);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_idx", 32'(idx), 32'h0);
        run(2);
        rst = 1'b0;
        tick();
        check_val("first_dead_an", 32'(an), 32'h0F);
        tick();
        check_val("first_slot_an", 32'(an), 32'h0E);
        run(4);

        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        run(16);

        load_digits(4'd0, 4'd0, 4'd7, 4'd0);
        run(16);

        load_digits(4'd0, 4'd0, 4'd0, 4'd12);
        run(4);
        d0 = 4'd5; d1 = 4'd6; d2 = 4'd7; d3 = 4'd8;
        run(16);

        guard_cnt = 0;
        while (m_presc != SD - 1 && guard_cnt < 8) begin
            tick();
            guard_cnt++;
        end
        if (m_presc != SD - 1) check_val("align_tmo", 32'd0, 32'd1);
        load_digits(4'd9, 4'd8, 4'd5, 4'd6);
        run(8);

        guard_cnt = 0;
        while (!(m_idx == 2 && m_presc == 2) && guard_cnt < 20) begin
            tick();
            guard_cnt++;
        end
        if (!(m_idx == 2 && m_presc == 2)) check_val("idx2_tmo", 32'd0, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_an",   32'(an),    32'h0F);
        check_val("mid_rst_seg",  32'(seg),   32'h7F);
        check_val("mid_rst_idx",  32'(idx),   32'h0);
        check_val("mid_rst_segb", 32'(seg_b), 32'h7F);
        m_presc = 0; m_idx = 0; m_shadow = 16'h0;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
